// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if
// Bundles everything that crosses the boundary of the register-file port-b
// arbiter, except clock and reset.
//   Requester side : req/we/addr/wdata/lock in, ack out for each of the two
//                    requesters, plus the shared rdata/err/lock_timeout/
//                    grant_id/busy status outputs.
//   Register file  : b_addr, b_data_in, b_wr_enable out, b_data_out in.
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters and register file)
interface regfile_port_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [4:0] addr0;
    logic [4:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       lock0;
    logic       lock1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       err;
    logic       lock_timeout;
    logic       grant_id;
    logic       busy;
    logic [4:0] b_addr;
    logic [7:0] b_data_in;
    logic       b_wr_enable;
    logic [7:0] b_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  lock0, lock1, b_data_out,
        output ack0, ack1, rdata, err, lock_timeout, grant_id, busy,
        output b_addr, b_data_in, b_wr_enable
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output lock0, lock1, b_data_out,
        input  ack0, ack1, rdata, err, lock_timeout, grant_id, busy,
        input  b_addr, b_data_in, b_wr_enable
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares register-file port b between requester 0 (CPU execute/writeback)
// and requester 1 (debug/host). Round-robin arbitration with a req/ack
// handshake, a bounded lock for read-modify-write sequences, and blocking
// of writes to the protected FLAG register.
// Ports:
//   clk     - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   bus     - regfile_port_arbiter_if.slave: requester handshakes, status
//             outputs and the register-file port-b signals
// Every access takes IDLE -> ACCESS -> RESP; a locked follow-on skips IDLE
// and goes RESP -> ACCESS directly.
module regfile_port_arbiter #(
    parameter logic [4:0] FLAG_ADDR = 5'd31,
    parameter int         LOCK_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    regfile_port_arbiter_if.slave bus
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] lock_count;
    logic          l_we;
    logic [4:0]    l_addr;
    logic [7:0]    l_wdata;
    logic          l_lock;

    logic          winner;
    logic          src;
    logic          sel_we;
    logic          sel_lock;
    logic [4:0]    sel_addr;
    logic [7:0]    sel_wdata;
    logic          served_req;
    logic          lock_last;
    logic          lock_continue;
    logic          load_grant;

    // Requester 1 wins if it is alone, or if both ask and 0 was served last.
    assign winner = bus.req1 & (~bus.req0 | ~last_grant);

    // In IDLE the fields come from the new winner; in RESP a locked
    // follow-on re-latches from the requester already being served.
    assign src       = (state == IDLE) ? winner : bus.grant_id;
    assign sel_we    = src ? bus.we1    : bus.we0;
    assign sel_addr  = src ? bus.addr1  : bus.addr0;
    assign sel_wdata = src ? bus.wdata1 : bus.wdata0;
    assign sel_lock  = src ? bus.lock1  : bus.lock0;

    assign served_req    = bus.grant_id ? bus.req1 : bus.req0;
    assign lock_last     = (lock_count == LAST_COUNT);
    assign lock_continue = l_lock & served_req & ~lock_last;
    assign load_grant    = ((state == IDLE) & (bus.req0 | bus.req1)) |
                           ((state == RESP) & lock_continue);

    // Single state machine with all outputs registered. Port-b drive values
    // are loaded on the edge that enters ACCESS so they are valid for the
    // whole ACCESS cycle; ack/err/lock_timeout are loaded on the edge that
    // enters RESP so they pulse together for exactly that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            lock_count       <= '0;
            l_we             <= 1'b0;
            l_addr           <= '0;
            l_wdata          <= '0;
            l_lock           <= 1'b0;
            bus.ack0         <= 1'b0;
            bus.ack1         <= 1'b0;
            bus.rdata        <= '0;
            bus.err          <= 1'b0;
            bus.lock_timeout <= 1'b0;
            bus.grant_id     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.b_addr       <= '0;
            bus.b_data_in    <= '0;
            bus.b_wr_enable  <= 1'b0;
        end else begin
            bus.ack0         <= 1'b0;
            bus.ack1         <= 1'b0;
            bus.err          <= 1'b0;
            bus.lock_timeout <= 1'b0;

            if (load_grant) begin
                l_we            <= sel_we;
                l_addr          <= sel_addr;
                l_wdata         <= sel_wdata;
                l_lock          <= sel_lock;
                bus.b_addr      <= sel_addr;
                bus.b_data_in   <= sel_wdata;
                bus.b_wr_enable <= sel_we & (sel_addr != FLAG_ADDR);
            end

            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        bus.grant_id <= winner;
                        last_grant   <= winner;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end

                ACCESS: begin
                    bus.rdata        <= bus.b_data_out;
                    bus.b_wr_enable  <= 1'b0;
                    bus.ack0         <= ~bus.grant_id;
                    bus.ack1         <= bus.grant_id;
                    bus.err          <= l_we & (l_addr == FLAG_ADDR);
                    // A lock on its last allowed access is broken with
                    // this ack, whether or not the owner still asks.
                    bus.lock_timeout <= l_lock & lock_last;
                    state            <= RESP;
                end

                RESP: begin
                    if (lock_continue) begin
                        lock_count <= lock_count + 1'b1;
                        state      <= ACCESS;
                    end else begin
                        lock_count <= '0;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
